// File: rtl/corescore_receiver_uart.sv
// 8N1 UART receiver: oversampled serial input, one-entry holding register with
// valid/ready handshake, single-cycle framing-error and overrun pulses.
module corescore_receiver_uart #(
  parameter int clk_freq_hz = 10000000,
  parameter int baud_rate   = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CLKS_PER_BIT = clk_freq_hz / baud_rate;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic          sync1, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_n;
  logic          valid_n, frame_err_n, overrun_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      sync1       <= i_uart_rx;
      rx_s        <= sync1;
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_data      <= data_n;
      o_valid     <= valid_n;
      o_frame_err <= frame_err_n;
      o_overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    data_n      = o_data;
    valid_n     = o_valid;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    // Pop first; a delivery in the same cycle overrides it below.
    if (o_valid && i_ready) valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_n = '0;
          if (rx_s) begin
            // Leave half a bit early so a back-to-back start edge is not missed.
            state_n = IDLE;
            if (!o_valid || i_ready) begin
              data_n  = shift;
              valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_corescore_receiver_uart.sv
// Self-checking bench for corescore_receiver_uart: vector table of frames plus
// hand-written handshake, error and reset sequences, with a byte scoreboard.
module tb_corescore_receiver_uart;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int deliveries = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] sb[$];

  corescore_receiver_uart #(.clk_freq_hz(10000000), .baud_rate(1000000)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_uart_rx(rx),
    .o_data(data),
    .o_valid(valid),
    .i_ready(ready),
    .o_frame_err(frame_err),
    .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic v_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (valid && (!v_prev || ready)) begin
        deliveries++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected none (t=%0t)", data, $time);
        end else begin
          chk("rx_byte", {24'd0, data}, {24'd0, sb.pop_front()});
        end
      end
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulses_together: got both high, expected at most one (t=%0t)", $time);
      end
      if ((frame_err && fe_prev) || (overrun && ov_prev)) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_width: got 2+ cycles, expected 1 (t=%0t)", $time);
      end
    end
    v_prev  = valid;
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; optional one-cycle ready pulse and reset at given
  // cycle offsets from the start-bit drive (-1 = none).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_at,
                            input int rst_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i % CPB == 0) rx = bits[i / CPB];
      if (i == rdy_at) ready = 1'b1;
      if (rdy_at >= 0 && i == rdy_at + 1) ready = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_data", {24'd0, data}, 32'd0);
        chk("async_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("async_rst_ovr", {31'd0, overrun}, 32'd0);
      end
      if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("pop_clears_valid", {31'd0, valid}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, d0, f0, o0;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[7] = '{8'hC3, 1'b1, 8'hC3, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Good byte and end-to-end latency with i_ready low.
    sb.push_back(8'hA5);
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, -1, -1);
      begin
        @(negedge clk);
        while (n < 200) begin
          @(posedge clk);
          #1;
          if (valid) break;
          n++;
        end
      end
    join
    chk("latency", n, 98);
    idle(10);
    chk("hold_valid", {31'd0, valid}, 32'd1);
    chk("hold_data", {24'd0, data}, 32'hA5);
    pop_one();
    chk("data_after_pop", {24'd0, data}, 32'hA5);

    // Start-bit glitch.
    d0 = deliveries; f0 = ferr_cnt; o0 = ovr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    chk("glitch_no_byte", deliveries - d0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    chk("glitch_no_ovr", ovr_cnt - o0, 0);

    // Vector table, consumer always ready.
    ready = 1'b1;
    foreach (vecs[i]) begin
      f0 = ferr_cnt;
      if (!vecs[i].exp_ferr) sb.push_back(vecs[i].exp_data);
      send_frame(vecs[i].tx, vecs[i].stop, -1, -1);
      idle(20);
      chk("vec_ferr", ferr_cnt - f0, {31'd0, vecs[i].exp_ferr});
      chk("vec_delivered", sb.size(), 0);
    end
    ready = 1'b0;

    // Break: 30 bit times low gives one frame error, then a clean byte.
    d0 = deliveries; f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    chk("break_one_ferr", ferr_cnt - f0, 1);
    chk("break_no_byte", deliveries - d0, 0);
    chk("break_valid_low", {31'd0, valid}, 32'd0);
    idle(20);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(5);
    chk("after_break_valid", {31'd0, valid}, 32'd1);
    chk("after_break_data", {24'd0, data}, 32'h3C);
    pop_one();

    // Overrun: second byte dropped while holding register is full.
    o0 = ovr_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    idle(5);
    chk("overrun_data", {24'd0, data}, 32'h11);
    chk("overrun_valid", {31'd0, valid}, 32'd1);
    chk("overrun_pulse", ovr_cnt - o0, 1);
    pop_one();

    // Pop in the same cycle as the second stop sample: no overrun.
    o0 = ovr_cnt;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, 98, -1);
    idle(5);
    chk("simpop_data", {24'd0, data}, 32'h22);
    chk("simpop_valid", {31'd0, valid}, 32'd1);
    chk("simpop_no_ovr", ovr_cnt - o0, 0);
    pop_one();

    // Reset during data bit 4 of 0xFF while a byte is held, then clean 0x5A.
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, -1, -1);
    idle(5);
    d0 = deliveries;
    send_frame(8'hFF, 1'b1, -1, 53);
    idle(20);
    chk("post_rst_no_byte", deliveries - d0, 0);
    chk("post_rst_valid", {31'd0, valid}, 32'd0);
    ready = 1'b1;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(20);
    chk("post_rst_5a_delivered", deliveries - d0, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of test, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
